issue_queue: RTL and testbench

- Collapsing out-of-order issue queue that drives the functional-unit dispatch interface (fu_input_t plus valid, per-FU ready vector).
- Buffers decoded, renamed instructions from dispatch and tracks source-operand readiness by snooping the writeback ports.
- Each cycle, issues the oldest entry whose operands are ready and whose target FU signals ready.
- Initiator side of the FU dispatch handshake; the FU block is the responder.

---
 rtl/issue_queue.sv | 188 ++++++++++++++++++
 tb/tb_issue_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue feeding the functional-unit dispatch
// interface. Slot 0 is always the oldest entry; occupied slots are contiguous.
// Source readiness is tracked by snooping the writeback ports.
// Optional feature macro: ISSUE_BYPASS_EN (empty-queue zero-latency issue).

package issue_queue_pkg;
  localparam int unsigned ROB_ID_W    = 4;
  localparam int unsigned NR_WB_PORTS = 2;
  localparam int unsigned NR_FU       = 4;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_MUL = 2'd2,
    FU_BRU = 2'd3
  } fu_t;

  typedef struct packed {
    fu_t                 fu;
    logic [3:0]          op;
    logic [31:0]         operand_a;
    logic [31:0]         operand_b;
    logic [ROB_ID_W-1:0] id;
  } fu_input_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] id;
    logic [31:0]         result;
  } fu_output_t;

  typedef logic [NR_WB_PORTS-1:0] wb_bitvector_t;
  typedef logic [NR_FU-1:0]       fu_bitvector_t;
endpackage

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = ROB_ID_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  fu_input_t                   disp_i,
  input  logic [TAG_W-1:0]            disp_rs1_tag_i,
  input  logic                        disp_rs1_rdy_i,
  input  logic [TAG_W-1:0]            disp_rs2_tag_i,
  input  logic                        disp_rs2_rdy_i,
  input  logic                        disp_valid_i,
  output logic                        disp_ready_o,
  input  fu_output_t [NR_WB_PORTS-1:0] fuoutput_i,
  input  wb_bitvector_t               fuoutput_i_valid,
  output fu_input_t                   fuinput_o,
  output logic                        fuinput_o_valid,
  input  fu_bitvector_t               fuinput_o_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             valid;
    fu_input_t        payload;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_rdy;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           woken [DEPTH];
  entry_t           nxt   [DEPTH];
  entry_t           in_entry;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] sel_idx;
  logic             sel_hit;
  fu_input_t        sel_payload;
  logic             issue;
  logic             bypass;
  logic             enq;
  logic             unused_wb_result;

  function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                   input fu_output_t [NR_WB_PORTS-1:0] wb,
                                   input wb_bitvector_t wb_valid);
    logic hit;
    hit = 1'b0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid[p] && (wb[p].id == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Writeback data is not needed here; fold it so the bits are consumed.
  always_comb begin
    unused_wb_result = 1'b0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      unused_wb_result = unused_wb_result ^ (^fuoutput_i[p].result);
    end
  end

  // Wakeup: mark sources whose producer is being written back this cycle.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken[i] = q[i];
      woken[i].rs1_rdy = q[i].rs1_rdy |
                         (q[i].valid & tag_hit(q[i].rs1_tag, fuoutput_i, fuoutput_i_valid));
      woken[i].rs2_rdy = q[i].rs2_rdy |
                         (q[i].valid & tag_hit(q[i].rs2_tag, fuoutput_i, fuoutput_i_valid));
    end
  end

  // Selection: oldest valid entry with both sources ready and its FU ready.
  always_comb begin
    sel_hit     = 1'b0;
    sel_idx     = '0;
    sel_payload = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_hit && q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy &&
          fuinput_o_ready[q[i].payload.fu]) begin
        sel_hit     = 1'b1;
        sel_idx     = CNT_W'(i);
        sel_payload = q[i].payload;
      end
    end
  end

`ifdef ISSUE_BYPASS_EN
  assign bypass = (count_q == '0) && !rst && !flush_i && disp_valid_i &&
                  disp_rs1_rdy_i && disp_rs2_rdy_i && fuinput_o_ready[disp_i.fu];
`else
  assign bypass = 1'b0;
`endif

  assign issue        = sel_hit && !rst && !flush_i;
  assign disp_ready_o = (count_q < CNT_W'(DEPTH));
  assign enq          = disp_valid_i && disp_ready_o && !flush_i && !rst && !bypass;
  assign wr_idx       = count_q - CNT_W'(issue);
  assign count_n      = count_q + CNT_W'(enq) - CNT_W'(issue);
  assign count_o      = count_q;

  // Issue port drive; zero whenever nothing is issued.
  always_comb begin
    fuinput_o_valid = issue | bypass;
    if (issue)       fuinput_o = sel_payload;
    else if (bypass) fuinput_o = disp_i;
    else             fuinput_o = '0;
  end

  // Incoming entry; a source written back this same cycle is stored ready.
  always_comb begin
    in_entry         = '0;
    in_entry.valid   = 1'b1;
    in_entry.payload = disp_i;
    in_entry.rs1_tag = disp_rs1_tag_i;
    in_entry.rs1_rdy = disp_rs1_rdy_i | tag_hit(disp_rs1_tag_i, fuoutput_i, fuoutput_i_valid);
    in_entry.rs2_tag = disp_rs2_tag_i;
    in_entry.rs2_rdy = disp_rs2_rdy_i | tag_hit(disp_rs2_tag_i, fuoutput_i, fuoutput_i_valid);
  end

  // Next queue image: collapse over the issued slot (wakeup already applied
  // in the old position, so it travels with the entry), then append.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (issue && (CNT_W'(i) >= sel_idx)) nxt[i] = woken[i+1];
      else                                 nxt[i] = woken[i];
    end
    if (issue) nxt[DEPTH-1] = '0;
    else       nxt[DEPTH-1] = woken[DEPTH-1];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (enq && (CNT_W'(i) == wr_idx)) nxt[i] = in_entry;
    end
  end

  // State update; reset and flush clear occupancy and take priority.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      count_q <= count_n;
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= nxt[i];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: a queue-based reference model predicts
// each cycle's issue; a negedge monitor compares DUT outputs against it.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = ROB_ID_W;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic                         clk;
  logic                         rst;
  logic                         flush_i;
  fu_input_t                    disp_i;
  logic [TAG_W-1:0]             disp_rs1_tag_i;
  logic                         disp_rs1_rdy_i;
  logic [TAG_W-1:0]             disp_rs2_tag_i;
  logic                         disp_rs2_rdy_i;
  logic                         disp_valid_i;
  logic                         disp_ready_o;
  fu_output_t [NR_WB_PORTS-1:0] fuoutput_i;
  wb_bitvector_t                fuoutput_i_valid;
  fu_input_t                    fuinput_o;
  logic                         fuinput_o_valid;
  fu_bitvector_t                fuinput_o_ready;
  logic [CNT_W-1:0]             count_o;

  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .disp_i           (disp_i),
    .disp_rs1_tag_i   (disp_rs1_tag_i),
    .disp_rs1_rdy_i   (disp_rs1_rdy_i),
    .disp_rs2_tag_i   (disp_rs2_tag_i),
    .disp_rs2_rdy_i   (disp_rs2_rdy_i),
    .disp_valid_i     (disp_valid_i),
    .disp_ready_o     (disp_ready_o),
    .fuoutput_i       (fuoutput_i),
    .fuoutput_i_valid (fuoutput_i_valid),
    .fuinput_o        (fuinput_o),
    .fuinput_o_valid  (fuinput_o_valid),
    .fuinput_o_ready  (fuinput_o_ready),
    .count_o          (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    fu_input_t        payload;
    logic [TAG_W-1:0] t1;
    bit               r1;
    logic [TAG_W-1:0] t2;
    bit               r2;
  } ref_entry_t;

  ref_entry_t model[$];
  fu_input_t  exp_q[$];
  int         exp_k;
  bit         exp_bypass;
  bit         exp_enq;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic bit wb_match(input logic [TAG_W-1:0] tag);
    for (int p = 0; p < NR_WB_PORTS; p++)
      if (fuoutput_i_valid[p] && fuoutput_i[p].id == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Predict this cycle's issue from the model and current inputs.
  task automatic model_expect();
    exp_k      = -1;
    exp_bypass = 1'b0;
    if (!rst && !flush_i) begin
      for (int k = 0; k < model.size(); k++) begin
        if (model[k].r1 && model[k].r2 && fuinput_o_ready[model[k].payload.fu]) begin
          exp_k = k;
          break;
        end
      end
`ifdef ISSUE_BYPASS_EN
      if (model.size() == 0 && disp_valid_i && disp_rs1_rdy_i && disp_rs2_rdy_i &&
          fuinput_o_ready[disp_i.fu])
        exp_bypass = 1'b1;
`endif
    end
    exp_enq = disp_valid_i && (model.size() < DEPTH) && !flush_i && !rst && !exp_bypass;
    if (exp_k >= 0)      exp_q.push_back(model[exp_k].payload);
    else if (exp_bypass) exp_q.push_back(disp_i);
  endtask

  task automatic model_update();
    ref_entry_t e;
    if (rst || flush_i) begin
      model.delete();
    end else begin
      if (exp_k >= 0) model.delete(exp_k);
      foreach (model[k]) begin
        if (wb_match(model[k].t1)) model[k].r1 = 1'b1;
        if (wb_match(model[k].t2)) model[k].r2 = 1'b1;
      end
      if (exp_enq) begin
        e.payload = disp_i;
        e.t1 = disp_rs1_tag_i;
        e.r1 = disp_rs1_rdy_i | wb_match(disp_rs1_tag_i);
        e.t2 = disp_rs2_tag_i;
        e.r2 = disp_rs2_rdy_i | wb_match(disp_rs2_tag_i);
        model.push_back(e);
      end
    end
  endtask

  task automatic tick();
    model_expect();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    flush_i          = 1'b0;
    disp_valid_i     = 1'b0;
    disp_rs1_rdy_i   = 1'b0;
    disp_rs2_rdy_i   = 1'b0;
    fuoutput_i_valid = '0;
  endtask

  task automatic disp(input fu_t fu, input bit r1, input int t1, input bit r2, input int t2);
    disp_valid_i        = 1'b1;
    disp_i.fu           = fu;
    disp_i.op           = 4'($urandom);
    disp_i.operand_a    = $urandom;
    disp_i.operand_b    = $urandom;
    disp_i.id           = ROB_ID_W'($urandom);
    disp_rs1_rdy_i      = r1;
    disp_rs1_tag_i      = TAG_W'(t1);
    disp_rs2_rdy_i      = r2;
    disp_rs2_tag_i      = TAG_W'(t2);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an issue.
  always @(negedge clk) begin
    fu_input_t e;
    n_vec++;
    if (count_o !== CNT_W'(model.size())) begin
      n_err++;
      $display("FAIL count_o: got %0d want %0d at %0t", count_o, model.size(), $time);
    end
    n_vec++;
    if (disp_ready_o !== (model.size() < DEPTH)) begin
      n_err++;
      $display("FAIL disp_ready_o: got %0b want %0b at %0t", disp_ready_o,
               (model.size() < DEPTH), $time);
    end
    if (fuinput_o_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_issue: got %h want no issue at %0t", fuinput_o, $time);
      end else begin
        e = exp_q.pop_front();
        if (fuinput_o !== e) begin
          n_err++;
          $display("FAIL issue_payload: got %h want %h at %0t", fuinput_o, e, $time);
        end
      end
    end else begin
      n_vec++;
      if (fuinput_o !== '0 || fuinput_o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_output: got valid=%b data=%h want 0/0 at %0t",
                 fuinput_o_valid, fuinput_o, $time);
      end
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missed_issue: got no issue want %h at %0t", exp_q[0], $time);
      exp_q.delete();
    end
  end

  initial begin
    disp_i          = '0;
    disp_rs1_tag_i  = '0;
    disp_rs2_tag_i  = '0;
    fuoutput_i      = '0;
    fuinput_o_ready = '1;
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Single ready ALU instruction.
    disp(FU_ALU, 1, 0, 1, 0);
    tick();
    set_idle();
    repeat (2) tick();

    // A waits on tag 5, younger B is ready and issues first.
    disp(FU_ALU, 0, 5, 1, 1);
    tick();
    disp(FU_MUL, 1, 2, 1, 3);
    tick();
    set_idle();
    repeat (3) tick();
    fuoutput_i[0].id = 4'd5;
    fuoutput_i_valid = 2'b01;
    tick();
    set_idle();
    repeat (2) tick();

    // Enqueue-cycle wakeup on WB port 1, tag 7.
    disp(FU_BRU, 1, 0, 0, 7);
    fuoutput_i[1].id = 4'd7;
    fuoutput_i_valid = 2'b10;
    tick();
    set_idle();
    repeat (2) tick();

    // Fill on a stalled LSU, one extra dispatch attempt, then release.
    fuinput_o_ready = 4'b1101;
    for (int i = 0; i < 9; i++) begin
      disp(FU_LSU, 1, 0, 1, 0);
      tick();
    end
    set_idle();
    tick();
    fuinput_o_ready = 4'b1111;
    repeat (10) tick();

    // Older LSU blocked, younger ALU bypasses it.
    fuinput_o_ready = 4'b1101;
    disp(FU_LSU, 1, 0, 1, 0);
    tick();
    disp(FU_ALU, 1, 0, 1, 0);
    tick();
    set_idle();
    repeat (2) tick();
    fuinput_o_ready = 4'b1111;
    repeat (2) tick();

    // Flush with 5 entries and a concurrent dispatch.
    fuinput_o_ready = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      disp(fu_t'(i % 4), 1, 0, 1, 0);
      tick();
    end
    disp(FU_ALU, 1, 0, 1, 0);
    flush_i = 1'b1;
    tick();
    set_idle();
    fuinput_o_ready = 4'b1111;
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      rst     = ($urandom_range(0, 199) == 0);
      flush_i = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) != 0)
        disp(fu_t'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
             $urandom_range(0, 1) != 0, $urandom_range(0, 7));
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        fuoutput_i[p].id     = ROB_ID_W'($urandom_range(0, 7));
        fuoutput_i[p].result = $urandom;
        fuoutput_i_valid[p]  = ($urandom_range(0, 1) != 0);
      end
      for (int f = 0; f < NR_FU; f++) fuinput_o_ready[f] = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    set_idle();
    fuinput_o_ready = '1;
    repeat (3) tick();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
